// File: rtl/cp0_regfile.sv
// ---------------------------------------------------------------------------
// cp0_regfile
// Coprocessor-0 register file for the five-stage MIPS core. Holds BadVAddr,
// Count, Compare, Status, Cause, EPC and PRId, applies exception/ERET commits
// from the exception unit, services MFC0/MTC0, samples the hardware interrupt
// lines and runs the Count/Compare timer.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   hw_int[5:0]              level interrupt lines, sampled into Cause.IP[7:2]
//   raddr, rdata             MFC0 read port (rdata combinational)
//   wen, waddr, wdata        MTC0 write port
//   exp_*                    exception/ERET commit from the exception unit
//   epc_address              current EPC
//   allow_interrupt          Status.IE & ~Status.EXL
//   interrupt_flag[7:0]      Cause.IP & Status.IM
//   timer_int                Cause.TI
// ---------------------------------------------------------------------------
module cp0_regfile #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
  parameter int unsigned COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        wen,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        exp_en,
  input  logic        exp_exl_clean,
  input  logic [31:0] exp_epc,
  input  logic [4:0]  exp_code,
  input  logic        exp_bd,
  input  logic [31:0] exp_bad_vaddr,
  input  logic        exp_bad_vaddr_wen,
  output logic [31:0] epc_address,
  output logic        allow_interrupt,
  output logic [7:0]  interrupt_flag,
  output logic        timer_int
);

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  logic [31:0]      badVAddr_q, badVAddr_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic [31:0]      epc_q, epc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       statusIm_q, statusIm_d;
  logic             statusExl_q, statusExl_d;
  logic             statusIe_q, statusIe_d;
  logic             causeBd_q, causeBd_d;
  logic             causeTi_q, causeTi_d;
  logic [7:0]       causeIp_q, causeIp_d;
  logic [4:0]       causeExc_q, causeExc_d;
  logic             divWrap;
  logic [31:0]      statusWord;
  logic [31:0]      causeWord;

  assign statusWord = {9'b0, 1'b1, 6'b0, statusIm_q, 6'b0, statusExl_q, statusIe_q};
  assign causeWord  = {causeBd_q, causeTi_q, 14'b0, causeIp_q, 1'b0, causeExc_q, 2'b0};

  // Next-state: timer and interrupt sampling first, then MTC0, then the
  // exception commit so that it overrides MTC0 on the fields it owns.
  always_comb begin
    badVAddr_d  = badVAddr_q;
    count_d     = count_q;
    compare_d   = compare_q;
    epc_d       = epc_q;
    statusIm_d  = statusIm_q;
    statusExl_d = statusExl_q;
    statusIe_d  = statusIe_q;
    causeBd_d   = causeBd_q;
    causeTi_d   = causeTi_q;
    causeIp_d   = causeIp_q;
    causeExc_d  = causeExc_q;

    divWrap = (div_q == DIV_LAST);
    div_d   = divWrap ? '0 : div_q + DIV_W'(1);
    if (divWrap) begin
      count_d = count_q + 32'd1;
    end

    // IP[7] merges the timer with hw_int[5]; uses the registered TI.
    causeIp_d[7:2] = {hw_int[5] | causeTi_q, hw_int[4:0]};

    if (divWrap && (count_q == compare_q)) begin
      causeTi_d = 1'b1;
    end

    if (wen) begin
      case (waddr)
        ADDR_COUNT: begin
          count_d = wdata;
          div_d   = '0;
        end
        ADDR_COMPARE: begin
          compare_d = wdata;
          causeTi_d = 1'b0;
        end
        ADDR_STATUS: begin
          statusIm_d  = wdata[15:8];
          statusExl_d = wdata[1];
          statusIe_d  = wdata[0];
        end
        ADDR_CAUSE: causeIp_d[1:0] = wdata[9:8];
        ADDR_EPC:   epc_d = wdata;
        default: ;
      endcase
    end

    if (exp_en) begin
      causeExc_d  = exp_code;
      statusExl_d = 1'b1;
      // Nested exceptions keep the original return address.
      if (!statusExl_q) begin
        epc_d     = exp_epc;
        causeBd_d = exp_bd;
      end
      if (exp_bad_vaddr_wen) begin
        badVAddr_d = exp_bad_vaddr;
      end
    end else if (exp_exl_clean) begin
      statusExl_d = 1'b0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badVAddr_q  <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      epc_q       <= '0;
      div_q       <= '0;
      statusIm_q  <= '0;
      statusExl_q <= 1'b0;
      statusIe_q  <= 1'b0;
      causeBd_q   <= 1'b0;
      causeTi_q   <= 1'b0;
      causeIp_q   <= '0;
      causeExc_q  <= '0;
    end else begin
      badVAddr_q  <= badVAddr_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      epc_q       <= epc_d;
      div_q       <= div_d;
      statusIm_q  <= statusIm_d;
      statusExl_q <= statusExl_d;
      statusIe_q  <= statusIe_d;
      causeBd_q   <= causeBd_d;
      causeTi_q   <= causeTi_d;
      causeIp_q   <= causeIp_d;
      causeExc_q  <= causeExc_d;
    end
  end

  // MFC0 read mux; unimplemented registers read zero.
  always_comb begin
    rdata = '0;
    case (raddr)
      ADDR_BADVADDR: rdata = badVAddr_q;
      ADDR_COUNT:    rdata = count_q;
      ADDR_COMPARE:  rdata = compare_q;
      ADDR_STATUS:   rdata = statusWord;
      ADDR_CAUSE:    rdata = causeWord;
      ADDR_EPC:      rdata = epc_q;
      ADDR_PRID:     rdata = PRID_VALUE;
      default:       rdata = '0;
    endcase
  end

  assign epc_address     = epc_q;
  assign allow_interrupt = statusIe_q & ~statusExl_q;
  assign interrupt_flag  = causeIp_q & statusIm_q;
  assign timer_int       = causeTi_q;

endmodule
